// File: rtl/rsa_io_if.sv
// Bundles the RSA I/O controller's stream, exponentiator and status signals.
// The controller uses the slave modport; its environment uses the master modport.
interface rsa_io_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [127:0] exp_m;
  logic [127:0] exp_e;
  logic [127:0] exp_n;
  logic         exp_start;
  logic [127:0] exp_c;
  logic         exp_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         err;
  logic         busy;

  modport slave (
    input  in_valid, in_data, exp_c, exp_ready, out_ready,
    output in_ready, exp_m, exp_e, exp_n, exp_start, out_valid, out_data, err, busy
  );

  modport master (
    output in_valid, in_data, exp_c, exp_ready, out_ready,
    input  in_ready, exp_m, exp_e, exp_n, exp_start, out_valid, out_data, err, busy
  );
endinterface

// File: rtl/rsa_io_ctrl.sv
// Loads m/e/n as twelve 32-bit words, kicks the exponentiator, then streams
// the 128-bit result out as four 32-bit words, LSW first.
//
// state | meaning
// LOAD  | accept operand words 0..11 into the shadow buffers
// START | exp_start held high for START_CYCLES cycles
// WAIT  | wait for exp_ready (first cycle ignored), capture exp_c
// DRAIN | present result words 0..3 on the output stream
module rsa_io_ctrl #(
  parameter int unsigned START_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  rsa_io_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [1:0]   k;
  logic [3:0]   start_tmr;
  logic         wait_first;
  logic         err_q;
  logic [127:0] buf_m, buf_e, buf_n;
  logic [127:0] op_m, op_e, op_n;
  logic [127:0] result;

  logic in_fire, out_fire, load_done, n_degen, capture;

  assign in_fire   = bus.in_valid && (state == LOAD);
  assign out_fire  = bus.out_ready && (state == DRAIN);
  assign load_done = in_fire && (cnt == 4'd11);
  // The last word is n[127:96]; n < 2 means it is zero and so is n[95:1].
  assign n_degen   = (bus.in_data == 32'd0) && (buf_n[95:1] == 95'd0);
  assign capture   = (state == WAIT) && !wait_first && bus.exp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_done) state_nxt = n_degen ? DRAIN : START;
      START:   if (start_tmr == 4'd0) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = DRAIN;
      DRAIN:   if (out_fire && (k == 2'd3)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      k          <= 2'd0;
      start_tmr  <= 4'd0;
      wait_first <= 1'b0;
      err_q      <= 1'b0;
      buf_m      <= '0;
      buf_e      <= '0;
      buf_n      <= '0;
      op_m       <= '0;
      op_e       <= '0;
      op_n       <= '0;
      result     <= '0;
    end else begin
      err_q <= 1'b0;
      if (in_fire) begin
        cnt <= load_done ? 4'd0 : cnt + 4'd1;
        case (cnt[3:2])
          2'd0:    buf_m[32*cnt[1:0] +: 32] <= bus.in_data;
          2'd1:    buf_e[32*cnt[1:0] +: 32] <= bus.in_data;
          default: buf_n[32*cnt[1:0] +: 32] <= bus.in_data;
        endcase
      end
      // Operands seen by the exponentiator change only when a full load completes.
      if (load_done) begin
        op_m      <= buf_m;
        op_e      <= buf_e;
        op_n      <= {bus.in_data, buf_n[95:0]};
        start_tmr <= 4'(START_CYCLES - 1);
        if (n_degen) begin
          result <= '0;
          err_q  <= 1'b1;
        end
      end
      if (state == START) begin
        wait_first <= 1'b1;
        if (start_tmr != 4'd0) start_tmr <= start_tmr - 4'd1;
      end else if (state == WAIT) begin
        wait_first <= 1'b0;
      end
      if (capture) result <= bus.exp_c;
      if (out_fire) k <= k + 2'd1;
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = (state == DRAIN) ? result[32*k +: 32] : 32'd0;
  assign bus.exp_start = (state == START);
  assign bus.exp_m     = op_m;
  assign bus.exp_e     = op_e;
  assign bus.exp_n     = op_n;
  assign bus.err       = err_q;
  assign bus.busy      = (state != LOAD);

endmodule

// File: tb/tb_rsa_io_ctrl.sv
// Directed bench for rsa_io_ctrl with a small behavioural exponentiator
// that answers with m^e mod n, or m^e^n when n does not fit in 64 bits.
module tb_rsa_io_ctrl;
  localparam int START_CYCLES = 2;
  localparam logic [127:0] GARBAGE = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_lat = 3;
  bit   early_rdy = 1'b0;
  int   ecnt;

  rsa_io_if bus ();

  rsa_io_ctrl #(.START_CYCLES(START_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] modexp(input logic [127:0] b, input logic [127:0] e,
                                          input logic [127:0] n);
    longint unsigned r, bb, nn;
    nn = n[63:0];
    if (nn == 0) return '0;
    r  = 1 % nn;
    bb = b[63:0] % nn;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * bb) % nn;
      bb = (bb * bb) % nn;
    end
    return {64'd0, r};
  endfunction

  // With early_rdy set, exp_ready is high with junk data through START and
  // the first WAIT cycle, which the controller must not capture.
  always @(posedge clk) begin
    if (!reset) begin
      ecnt          <= 0;
      bus.exp_ready <= 1'b0;
      bus.exp_c     <= '0;
    end else if (bus.exp_start) begin
      ecnt          <= exp_lat;
      bus.exp_ready <= early_rdy;
      bus.exp_c     <= early_rdy ? GARBAGE : 128'd0;
    end else if (ecnt != 0) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) begin
        bus.exp_ready <= 1'b1;
        bus.exp_c     <= (bus.exp_n[127:64] != 0) ? (bus.exp_m ^ bus.exp_e ^ bus.exp_n)
                                                  : modexp(bus.exp_m, bus.exp_e, bus.exp_n);
      end else begin
        bus.exp_ready <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [127:0] m, input logic [127:0] e, input logic [127:0] n,
                         input bit gap);
    logic [127:0] ops[3];
    ops[0] = m;
    ops[1] = e;
    ops[2] = n;
    for (int i = 0; i < 12; i++) begin
      int w;
      if (gap) begin
        bus.in_valid = 1'b0;
        step();
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ops[i/4][32*(i%4) +: 32];
      w = 0;
      while (!bus.in_ready && w < 100) begin
        step();
        w++;
      end
      if (w >= 100) chk("in_ready_wait", bus.in_ready, 1);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input logic [127:0] res, input bit toggle);
    for (int i = 0; i < 4; i++) begin
      if (toggle) begin
        bus.out_ready = 1'b0;
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, res[32*i +: 32]);
        chk("stall_in_ready", bus.in_ready, 0);
        step();
      end
      bus.out_ready = 1'b1;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, res[32*i +: 32]);
      chk("drain_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b0;
    chk("done_in_ready", bus.in_ready, 1);
    chk("done_out_valid", bus.out_valid, 0);
  endtask

  task automatic run_op(input logic [127:0] m, input logic [127:0] e, input logic [127:0] n,
                        input logic [127:0] res, input bit gap, input bit junk,
                        input bit toggle, input bit degen);
    int lat, starts, errs;
    load_op(m, e, n, gap);
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hdead_beef;
    end
    lat = 0;
    starts = 0;
    errs = 0;
    while (!bus.out_valid && lat < 200) begin
      starts += int'(bus.exp_start);
      errs   += int'(bus.err);
      step();
      lat++;
    end
    errs += int'(bus.err);
    chk("out_valid_seen", bus.out_valid, 1);
    // Edges after the completing handshake: START, one ignored WAIT cycle,
    // the exponentiator latency, then the capture edge.
    chk("latency", lat, degen ? 0 : START_CYCLES + exp_lat + 1);
    chk("start_cycles", starts, degen ? 0 : START_CYCLES);
    chk("err_pulses", errs, degen ? 1 : 0);
    if (!degen) begin
      chk("exp_m", bus.exp_m, m);
      chk("exp_e", bus.exp_e, e);
      chk("exp_n", bus.exp_n, n);
    end
    bus.in_valid = 1'b0;
    drain(res, toggle);
    chk("err_after", bus.err, 0);
  endtask

  initial begin
    logic [127:0] wm, we, wn;
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_exp_start", bus.exp_start, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_exp_n", bus.exp_n, 0);
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    run_op(128'd4, 128'd13, 128'd497, 128'd445, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(128'd7, 128'd0, 128'd11, 128'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(128'd5, 128'd3, 128'd1, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    early_rdy = 1'b1;
    run_op(128'd3, 128'd7, 128'd100, 128'd87, 1'b1, 1'b1, 1'b0, 1'b0);
    early_rdy = 1'b0;
    run_op(128'd5, 128'd3, 128'd13, 128'd8, 1'b0, 1'b0, 1'b0, 1'b0);

    wm = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    we = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
    wn = 128'h8f8e8d8c_8b8a8988_87868584_83828180;
    run_op(wm, we, wn, wm ^ we ^ wn, 1'b1, 1'b0, 1'b1, 1'b0);

    exp_lat = 20;
    load_op(128'd3, 128'd5, 128'd7, 1'b0);
    repeat (5) step();
    chk("mid_wait_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_exp_m", bus.exp_m, 0);
    chk("arst_exp_start", bus.exp_start, 0);
    chk("arst_out_data", bus.out_data, 0);
    step();
    step();
    reset = 1'b1;
    chk("arst_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      seen += int'(bus.out_valid);
      step();
    end
    chk("no_stale_output", seen, 0);
    exp_lat = 3;
    run_op(128'd2, 128'd10, 128'd1000, 128'd24, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
